pico_ctrl_seq: RTL and testbench
================================

# pico_ctrl_seq

Single-cycle instruction sequencer for the PicoCtrl controller. Holds the program counter, fetches 16-bit instructions from the 32-word combinational instruction ROM, evaluates a condition on external status inputs, and executes write, jump or delay actions. Drives four 8-bit output registers that control downstream datapath logic. Sits between the instruction ROM and the controlled datapath.

## Interface

Parameters:
- `NREG`, 4: number of output registers (fixed at 4 by the 2-bit register field).
- `AW`, 5: ROM address width (32 words).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  1 = execute; 0 = freeze the PC, delay counter and outputs.
- `cond_in`  in  4  status inputs c0..c3 tested by instruction conditions.
- `rom_addr`  out  5  current PC; drives ROM `addr`.
- `rom_data`  in  16  instruction returned combinationally by the ROM.
- `out_regs`  out  32  {reg3, reg2, reg1, reg0}, 8 bits each.
- `out_wr`  out  4  one-cycle pulse: bit i is high the cycle after reg i is written.
- `busy`  out  1  high while a delay instruction is stalling.

## Operation

- Instruction fields:
  - `[15]`: condition enable. 0 = always true.
  - `[14:13]`: condition input select c[sel].
  - `[12]`: required value. The condition is true when `c[sel] == [12]`.
  - `[11:10]`: action. 00 = nop, 01 = write, 10 = jump, 11 = delay.
  - `[9:8]`: target register.
  - `[7:0]`: immediate.
- Condition false: the instruction acts as a nop, and the PC advances by 1.
- Nop: PC advances by 1.
- Write: `reg[[9:8]] <= imm`. PC advances by 1.
- Jump: `PC <= imm[4:0]`. `imm[7:5]` is ignored. Jump to self is the busy-wait idiom.
- Delay: behaviour depends on `imm`.
  - `imm == 0`: behaves as a nop.
  - Otherwise: enter DELAY, load `cnt = imm`, hold the PC, and assert `busy`. `cnt` decrements each running cycle. When `cnt` reaches 1, the next cycle advances the PC.
  - Total cycles spent on the instruction: `imm + 1`.
- State machine:
  - EXEC → DELAY on a true delay condition with `imm != 0`.
  - DELAY → EXEC on the cycle `cnt == 1`. PC advances on that cycle.
  - The condition is not re-evaluated during DELAY.
- PC arithmetic is modulo 32: 31 + 1 = 0.
- `run = 0`: no register writes, `out_wr = 0`, PC/`cnt`/state hold, `busy` holds its value.
- Reset (any time, including mid-delay) forces the following. Outputs are valid the cycle after reset is sampled.
  - PC = 0, state = EXEC, `cnt` = 0.
  - All `out_regs` = 0x00, `out_wr` = 0, `busy` = 0.
  - An in-progress delay is aborted.

## Timing

- Fetch and decode complete in one cycle. `rom_addr` is registered; `rom_data` is used in the same cycle.
- Write result appears on `out_regs` one cycle after the instruction is presented. `out_wr` pulses in that same cycle.
- Condition inputs are sampled in the cycle the instruction is at `rom_addr`.
- Throughput: one instruction per cycle, except delay instructions.
- `reset` has priority over `run`.

## Configuration

- `PICO_SYNC_INPUTS_EN` defined: `cond_in` passes through a two-flop synchronizer before evaluation.
  - Adds 2 cycles of input-to-decision latency.
  - Synchronizer flops reset to 0.
- `PICO_SYNC_INPUTS_EN` undefined: `cond_in` is used directly with zero added latency. The inputs must already be synchronous to `clk`.

## Test plan

- Reset: assert `reset` mid-program and mid-delay. Required next cycle: `rom_addr = 0`, `out_regs = 0`, `busy = 0`, `out_wr = 0`.
- Write: ROM[0] = write reg2 with 0xA5, cond off. After 1 cycle: `out_regs[23:16] = 0xA5`, `out_wr = 4'b0100`, `rom_addr = 1`.
- Busy-wait: ROM[1] = if c1 == 1 jump to 0x01, `cond_in[1] = 1`.
  - Required: `rom_addr` stays at 1.
  - Drop `cond_in[1]` to 0: the next cycle `rom_addr = 2` (2 cycles later with the macro defined).
- Delay: ROM[3] = delay `imm = 5`.
  - Required: `busy` high and `rom_addr = 3` for exactly 6 cycles total, then `rom_addr = 4`.
  - Repeat with `imm = 0`: `rom_addr = 4` after 1 cycle.
- Wrap and jump masking:
  - Nops through address 31: next `rom_addr = 0`.
  - Jump with `imm = 0xE7`: target = 7.
- Freeze: deassert `run` during a delay with `cnt = 3` for 4 cycles. Required: PC, `cnt` and `busy` unchanged; delay resumes with 3 remaining.

Source files
------------

// File: rtl/pico_ctrl_seq.sv
// PicoCtrl single-cycle instruction sequencer: PC, condition test, write/jump/delay actions.
// Optional PICO_SYNC_INPUTS_EN adds a two-flop synchronizer on cond_in.
module pico_ctrl_seq #(
  parameter int NREG = 4,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [3:0]        cond_in,
  output logic [AW-1:0]     rom_addr,
  input  logic [15:0]       rom_data,
  output logic [8*NREG-1:0] out_regs,
  output logic [NREG-1:0]   out_wr,
  output logic              busy
);

  typedef enum logic {
    EXEC  = 1'b0,
    DELAY = 1'b1
  } state_t;

  localparam logic [1:0] ACT_NOP   = 2'b00;
  localparam logic [1:0] ACT_WRITE = 2'b01;
  localparam logic [1:0] ACT_JUMP  = 2'b10;
  localparam logic [1:0] ACT_DELAY = 2'b11;

  state_t          state_reg, state_next;
  logic [AW-1:0]   pc_reg, pc_next;
  logic [7:0]      cnt_reg, cnt_next;
  logic [7:0]      regs_reg [NREG];
  logic [NREG-1:0] wr_reg, wr_next;
  logic            wr_en;
  logic [3:0]      cond_eval;

`ifdef PICO_SYNC_INPUTS_EN
  logic [3:0] sync1_reg, sync2_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= cond_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign cond_eval = sync2_reg;
`else
  assign cond_eval = cond_in;
`endif

  logic       cond_en;
  logic [1:0] cond_sel;
  logic       cond_val;
  logic [1:0] act;
  logic [1:0] tgt;
  logic [7:0] imm;
  logic       cond_true;

  assign cond_en   = rom_data[15];
  assign cond_sel  = rom_data[14:13];
  assign cond_val  = rom_data[12];
  assign act       = rom_data[11:10];
  assign tgt       = rom_data[9:8];
  assign imm       = rom_data[7:0];
  assign cond_true = !cond_en || (cond_eval[cond_sel] == cond_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EXEC;
      pc_reg    <= '0;
      cnt_reg   <= '0;
      wr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      wr_reg    <= wr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    wr_next    = '0;
    wr_en      = 1'b0;
    if (run) begin
      case (state_reg)
        EXEC: begin
          if (!cond_true) begin
            pc_next = pc_reg + 1'b1;
          end else begin
            case (act)
              ACT_NOP: pc_next = pc_reg + 1'b1;
              ACT_WRITE: begin
                wr_en        = 1'b1;
                wr_next[tgt] = 1'b1;
                pc_next      = pc_reg + 1'b1;
              end
              ACT_JUMP: pc_next = imm[AW-1:0];
              ACT_DELAY: begin
                if (imm == 8'd0) begin
                  pc_next = pc_reg + 1'b1;
                end else begin
                  state_next = DELAY;
                  cnt_next   = imm;
                end
              end
              default: pc_next = pc_reg + 1'b1;
            endcase
          end
        end
        DELAY: begin
          // The condition is deliberately not re-evaluated while stalling.
          if (cnt_reg == 8'd1) begin
            state_next = EXEC;
            cnt_next   = 8'd0;
            pc_next    = pc_reg + 1'b1;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        default: state_next = EXEC;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_regs
      always_ff @(posedge clk) begin
        if (reset) begin
          regs_reg[gi] <= 8'h00;
        end else if (wr_en && (tgt == gi[1:0])) begin
          regs_reg[gi] <= imm;
        end
      end
      assign out_regs[8*gi +: 8] = regs_reg[gi];
    end
  endgenerate

  // Busy covers the deciding EXEC cycle too, so it spans all imm+1 stalled cycles.
  assign busy = (state_reg == DELAY) ||
                ((state_reg == EXEC) && cond_true && (act == ACT_DELAY) && (imm != 8'd0));

  assign rom_addr = pc_reg;
  assign out_wr   = wr_reg;

endmodule

// File: tb/tb_pico_ctrl_seq.sv
// Directed self-checking bench for pico_ctrl_seq running a small ROM program.
module tb_pico_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [3:0]  cond_in;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic [31:0] out_regs;
  logic [3:0]  out_wr;
  logic        busy;

  logic [15:0] rom [32];
  int checks = 0;
  int errors = 0;

`ifdef PICO_SYNC_INPUTS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  pico_ctrl_seq dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .cond_in  (cond_in),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .out_regs (out_regs),
    .out_wr   (out_wr),
    .busy     (busy)
  );

  function automatic logic [15:0] enc(input logic cen, input logic [1:0] sel, input logic val,
                                      input logic [1:0] act, input logic [1:0] tgt,
                                      input logic [7:0] imm);
    return {cen, sel, val, act, tgt, imm};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", rom_addr); end
    checks++; if (out_regs !== 32'h0) begin errors++; $display("FAIL reset_regs: got %h expected 00000000", out_regs); end
    checks++; if (out_wr !== 4'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0000", out_wr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    $display("test_reset: pc=%0d regs=%h", rom_addr, out_regs);
    reset = 1'b0;
  endtask

  task automatic test_write;
    step(1);
    checks++; if (out_regs[23:16] !== 8'hA5) begin errors++; $display("FAIL write_reg2: got %h expected a5", out_regs[23:16]); end
    checks++; if (out_wr !== 4'b0100) begin errors++; $display("FAIL write_wr: got %b expected 0100", out_wr); end
    checks++; if (rom_addr !== 5'd1) begin errors++; $display("FAIL write_pc: got %0d expected 1", rom_addr); end
    $display("test_write: regs=%h wr=%b pc=%0d", out_regs, out_wr, rom_addr);
  endtask

  task automatic test_busy_wait;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (rom_addr !== 5'd1) begin errors++; $display("FAIL spin_pc[%0d]: got %0d expected 1", i, rom_addr); end
      checks++; if (out_wr !== 4'b0) begin errors++; $display("FAIL spin_wr[%0d]: got %b expected 0000", i, out_wr); end
    end
    cond_in[1] = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      step(1);
      checks++; if (rom_addr !== 5'd1) begin errors++; $display("FAIL spin_lat[%0d]: got %0d expected 1", i, rom_addr); end
    end
    step(1);
    checks++; if (rom_addr !== 5'd2) begin errors++; $display("FAIL spin_exit: got %0d expected 2", rom_addr); end
    step(1);
    checks++; if (out_regs !== 32'h00A5_3C00) begin errors++; $display("FAIL write_reg1: got %h expected 00a53c00", out_regs); end
    checks++; if (out_wr !== 4'b0010) begin errors++; $display("FAIL write1_wr: got %b expected 0010", out_wr); end
    $display("test_busy_wait: pc=%0d regs=%h", rom_addr, out_regs);
  endtask

  task automatic test_delay;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1);
      checks++; if (rom_addr !== 5'd3) begin errors++; $display("FAIL delay_pc[%0d]: got %0d expected 3", i, rom_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL delay_busy[%0d]: got %b expected 1", i, busy); end
    end
    step(1);
    checks++; if (rom_addr !== 5'd4) begin errors++; $display("FAIL delay_done: got %0d expected 4", rom_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL delay0_busy: got %b expected 0", busy); end
    step(1);
    checks++; if (rom_addr !== 5'd5) begin errors++; $display("FAIL delay0_pc: got %0d expected 5", rom_addr); end
    $display("test_delay: pc=%0d busy=%b", rom_addr, busy);
  endtask

  task automatic test_jump_wrap;
    step(1);
    checks++; if (rom_addr !== 5'd7) begin errors++; $display("FAIL jump_mask: got %0d expected 7", rom_addr); end
    step(1);
    checks++; if (rom_addr !== 5'd8) begin errors++; $display("FAIL cond_false_pc: got %0d expected 8", rom_addr); end
    checks++; if (out_wr !== 4'b0) begin errors++; $display("FAIL cond_false_wr: got %b expected 0000", out_wr); end
    step(1);
    checks++; if (out_regs[31:24] !== 8'h42) begin errors++; $display("FAIL cond_true_reg3: got %h expected 42", out_regs[31:24]); end
    checks++; if (out_wr !== 4'b1000) begin errors++; $display("FAIL cond_true_wr: got %b expected 1000", out_wr); end
    step(1);
    checks++; if (rom_addr !== 5'd30) begin errors++; $display("FAIL jump30: got %0d expected 30", rom_addr); end
    step(2);
    checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL wrap: got %0d expected 0", rom_addr); end
    $display("test_jump_wrap: pc=%0d regs=%h", rom_addr, out_regs);
  endtask

  task automatic test_freeze;
    step(3);
    checks++; if (rom_addr !== 5'd3) begin errors++; $display("FAIL freeze_reach: got %0d expected 3", rom_addr); end
    step(3);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++; if (rom_addr !== 5'd3) begin errors++; $display("FAIL freeze_pc[%0d]: got %0d expected 3", i, rom_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL freeze_busy[%0d]: got %b expected 1", i, busy); end
    end
    run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      checks++; if (rom_addr !== 5'd3) begin errors++; $display("FAIL resume_pc[%0d]: got %0d expected 3", i, rom_addr); end
    end
    step(1);
    checks++; if (rom_addr !== 5'd4) begin errors++; $display("FAIL resume_done: got %0d expected 4", rom_addr); end
    $display("test_freeze: pc=%0d busy=%b", rom_addr, busy);
  endtask

  task automatic test_reset_mid;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_delay_busy: got %b expected 1", busy); end
    reset = 1'b1;
    step(1);
    checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL abort_pc: got %0d expected 0", rom_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (out_regs !== 32'h0) begin errors++; $display("FAIL abort_regs: got %h expected 00000000", out_regs); end
    reset = 1'b0;
    step(1);
    checks++; if (out_wr !== 4'b0100) begin errors++; $display("FAIL post_abort_wr: got %b expected 0100", out_wr); end
    reset = 1'b1;
    step(1);
    checks++; if (out_wr !== 4'b0) begin errors++; $display("FAIL reset_wr_pulse: got %b expected 0000", out_wr); end
    checks++; if (out_regs !== 32'h0) begin errors++; $display("FAIL reset_regs2: got %h expected 00000000", out_regs); end
    reset = 1'b0;
    $display("test_reset_mid: pc=%0d busy=%b", rom_addr, busy);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    rom[0] = enc(1'b0, 2'd0, 1'b0, 2'b01, 2'd2, 8'hA5);
    rom[1] = enc(1'b1, 2'd1, 1'b1, 2'b10, 2'd0, 8'h01);
    rom[2] = enc(1'b0, 2'd0, 1'b0, 2'b01, 2'd1, 8'h3C);
    rom[3] = enc(1'b0, 2'd0, 1'b0, 2'b11, 2'd0, 8'd5);
    rom[4] = enc(1'b0, 2'd0, 1'b0, 2'b11, 2'd0, 8'd0);
    rom[5] = enc(1'b0, 2'd0, 1'b0, 2'b10, 2'd0, 8'hE7);
    rom[6] = enc(1'b0, 2'd0, 1'b0, 2'b01, 2'd0, 8'hFF);
    rom[7] = enc(1'b1, 2'd2, 1'b1, 2'b01, 2'd3, 8'h77);
    rom[8] = enc(1'b1, 2'd0, 1'b0, 2'b01, 2'd3, 8'h42);
    rom[9] = enc(1'b0, 2'd0, 1'b0, 2'b10, 2'd0, 8'h1E);
    reset   = 1'b1;
    run     = 1'b1;
    cond_in = 4'b0010;
    test_reset;
    test_write;
    test_busy_wait;
    test_delay;
    test_jump_wrap;
    test_freeze;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
